id_fwd_hazard: RTL and testbench
================================

Name: id_fwd_hazard

Overview:
- Parametrised decode-stage operand-forwarding and hazard unit; successor to the fixed 4-source, load/CSR-only ID bypass logic.
- Sits between the decoder/regfile read and the ID/EX register; drives `src1`/`src2`, `stallreq` and `issue`.
- Generalises bypass to NBYP sources, each carrying a per-source data-ready flag.
- Adds a register scoreboard for multi-cycle writers (div/long ops), with an outstanding-op limit and a stall-cycle counter.

Parameters:
- XLEN, 32, datapath width
- AW, 5, register address width (2**AW registers, x0 hardwired zero)
- NBYP, 4, number of bypass sources; index 0 = youngest stage, highest priority
- MAX_LONG, 2, maximum outstanding long-latency ops (1..2**AW-1)
- CW, 16, stall-counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- stall_in  in  1  downstream holds ID (ID/EX not accepting)
- flush  in  1  branch/redirect kills the instruction in ID this cycle
- in_valid  in  1  ID holds a valid instruction
- in_rs1, in_rs2  in  AW each  source register addresses
- in_rs1_en, in_rs2_en  in  1 each  source actually read (from decoder)
- in_rd  in  AW  destination register
- in_rd_we  in  1  instruction writes rd
- in_long  in  1  instruction is a multi-cycle writer
- rf_rdata1, rf_rdata2  in  XLEN each  regfile read data
- byp_bus  in  NBYP*(2+AW+XLEN)  entry i = {we, ready, waddr, wdata}
- lw_valid  in  1  long-op completion (writeback) strobe
- lw_waddr  in  AW  register completed by the long op
- src1, src2  out  XLEN each  forwarded operands
- stallreq  out  1  ID must hold
- issue  out  1  instruction leaves ID this cycle
- sb_busy  out  2**AW  scoreboard vector
- long_cnt  out  $clog2(MAX_LONG+1)  outstanding long ops
- stall_cnt  out  CW  saturating count of cycles with stallreq=1

Behaviour:
- Reset (async, rst=1): sb_busy=0, long_cnt=0, stall_cnt=0. Combinational outputs follow their inputs.
- Forwarding (combinational, per source s∈{1,2}):
  - A source reading x0 or with rsX_en=0 never matches any bypass entry and never stalls.
  - src = lowest index i with we_i & waddr_i==rsX & rsX!=0 ⇒ wdata_i; no match ⇒ rf_rdataX; rsX==0 ⇒ 0.
  - Only the highest-priority match is considered. If that entry has ready=0 ⇒ raw stall, even when an older entry is ready.
- Scoreboard:
  - clr = lw_valid & lw_waddr!=0 ⇒ onehot(lw_waddr). busy_eff = sb_busy & ~clr (completion visible same cycle).
  - sb stall: rsX_en & busy_eff[rsX]. WAW stall: in_rd_we & busy_eff[in_rd].
  - Cap stall: in_long & (long_cnt - (lw_valid?1:0)) == MAX_LONG.
  - stallreq = in_valid & (raw|sb|WAW|cap stall). It is not gated by stall_in or flush.
  - issue = in_valid & ~stallreq & ~stall_in & ~flush.
- Scoreboard set: at posedge clk, if issue & in_long & in_rd_we & in_rd!=0, set sb_busy[in_rd]. If set and clear hit the same register, set wins.
- long_cnt: next = long_cnt + (issue & in_long) − lw_valid.
  - lw_valid with long_cnt==0 is illegal; the design holds 0 and does not underflow.
  - in_long with in_rd==0 or in_rd_we==0 still counts.
- Flush semantics: flush affects only ID. Issued long ops always complete, so scoreboard and long_cnt are not cleared.
- stall_cnt: increments when stallreq=1 and saturates at 2**CW−1.

Test Plan:
- Entry 1 {we=1, ready=1, waddr=5, wdata=0xAAAA0001}, entry 3 {we=1, ready=1, waddr=5, wdata=0x0000BBBB}, rs1=5 ⇒ src1=0xAAAA0001, stallreq=0.
- Entry 0 {we=1, ready=0, waddr=7}, entry 2 {we=1, ready=1, waddr=7}, rs2=7 ⇒ stallreq=1, issue=0. Next cycle entry 0 has ready=1, wdata=0x1234 ⇒ src2=0x1234, issue=1.
- rs1=0 with entry 0 {we=1, waddr=0, ready=0} ⇒ src1=0, stallreq=0.
- Long op rd=9 issues ⇒ sb_busy[9]=1, long_cnt=1. Next instruction reads x9 ⇒ stall until lw_valid, lw_waddr=9. In that same cycle issue=1 (bypassed clear); next cycle sb_busy[9]=0, long_cnt=0.
- MAX_LONG=2: two long ops issue, a third in_long stalls. Assert lw_valid on the same cycle ⇒ third issues, long_cnt stays 2. Also: lw_valid for rd=9 with a new long op to rd=9 on the same cycle ⇒ sb_busy[9]=1 afterwards (set wins).
- Hold a stall 5 cycles ⇒ stall_cnt=5. Assert rst mid-stall ⇒ stall_cnt, sb_busy, long_cnt all 0 immediately, without waiting for a clock edge. Flush with outstanding op ⇒ sb_busy unchanged.

Source files
------------

// File: rtl/id_fwd_hazard.sv
// rtl/id_fwd_hazard.sv - decode-stage operand forwarding, scoreboard and hazard unit
module id_fwd_hazard #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NBYP     = 4,
    parameter int MAX_LONG = 2,
    parameter int CW       = 16,
    localparam int BW      = 2 + AW + XLEN,
    localparam int NR      = 2 ** AW,
    localparam int LCW     = $clog2(MAX_LONG + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_in,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [AW-1:0]        in_rs1,
    input  logic [AW-1:0]        in_rs2,
    input  logic                 in_rs1_en,
    input  logic                 in_rs2_en,
    input  logic [AW-1:0]        in_rd,
    input  logic                 in_rd_we,
    input  logic                 in_long,
    input  logic [XLEN-1:0]      rf_rdata1,
    input  logic [XLEN-1:0]      rf_rdata2,
    input  logic [NBYP*BW-1:0]   byp_bus,
    input  logic                 lw_valid,
    input  logic [AW-1:0]        lw_waddr,
    output logic [XLEN-1:0]      src1,
    output logic [XLEN-1:0]      src2,
    output logic                 stallreq,
    output logic                 issue,
    output logic [NR-1:0]        sb_busy,
    output logic [LCW-1:0]       long_cnt,
    output logic [CW-1:0]        stall_cnt
);

    logic [NR-1:0]  sb_busy_q, sb_busy_d;
    logic [LCW-1:0] long_cnt_q, long_cnt_d;
    logic [CW-1:0]  stall_cnt_q, stall_cnt_d;

    logic [NR-1:0]  clr, set, busy_eff;
    logic           rdy1, rdy2;
    logic           raw_stall, sb_stall, waw_stall, cap_stall;
    logic [LCW:0]   cnt_adj;

    // Returns {ready, data}; walking from oldest to youngest lets the youngest match win.
    function automatic logic [XLEN:0] fwd(input logic [AW-1:0] rs, input logic en,
                                          input logic [XLEN-1:0] rdata,
                                          input logic [NBYP*BW-1:0] bus);
        logic [XLEN:0] r;
        logic [BW-1:0] ent;
        r = {1'b1, rdata};
        for (int i = NBYP - 1; i >= 0; i--) begin
            ent = bus[i*BW +: BW];
            if (ent[BW-1] && en && (rs != '0) && (ent[XLEN +: AW] == rs))
                r = {ent[BW-2], ent[XLEN-1:0]};
        end
        if (rs == '0)
            r = {1'b1, {XLEN{1'b0}}};
        return r;
    endfunction

    always_comb begin
        {rdy1, src1} = fwd(in_rs1, in_rs1_en, rf_rdata1, byp_bus);
        {rdy2, src2} = fwd(in_rs2, in_rs2_en, rf_rdata2, byp_bus);
        raw_stall = ~rdy1 | ~rdy2;
    end

    // A completing long op releases its register in the same cycle it writes back.
    always_comb begin
        clr = '0;
        if (lw_valid && (lw_waddr != '0))
            clr[lw_waddr] = 1'b1;
        busy_eff  = sb_busy_q & ~clr;
        sb_stall  = (in_rs1_en & busy_eff[in_rs1]) | (in_rs2_en & busy_eff[in_rs2]);
        waw_stall = in_rd_we & busy_eff[in_rd];
        cnt_adj   = {1'b0, long_cnt_q} - {{LCW{1'b0}}, lw_valid};
        cap_stall = in_long & (cnt_adj == (LCW+1)'(MAX_LONG));
        stallreq  = in_valid & (raw_stall | sb_stall | waw_stall | cap_stall);
        issue     = in_valid & ~stallreq & ~stall_in & ~flush;
    end

    always_comb begin
        set = '0;
        if (issue && in_long && in_rd_we && (in_rd != '0))
            set[in_rd] = 1'b1;
        sb_busy_d = busy_eff | set;

        long_cnt_d = long_cnt_q;
        case ({issue & in_long, lw_valid})
            2'b10:   long_cnt_d = long_cnt_q + LCW'(1);
            2'b01:   if (long_cnt_q != '0) long_cnt_d = long_cnt_q - LCW'(1);
            default: long_cnt_d = long_cnt_q;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (stallreq && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_busy_q   <= '0;
            long_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            sb_busy_q   <= sb_busy_d;
            long_cnt_q  <= long_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sb_busy   = sb_busy_q;
    assign long_cnt  = long_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_fwd_hazard.sv
// tb/tb_id_fwd_hazard.sv - directed bench for id_fwd_hazard with an expectation queue
module tb_id_fwd_hazard;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NBYP = 4;
    localparam int BW   = 2 + AW + XLEN;

    localparam int S_SRC1 = 0, S_SRC2 = 1, S_STALL = 2, S_ISSUE = 3,
                   S_BUSY = 4, S_LCNT = 5, S_SCNT = 6;

    logic              clk, rst, stall_in, flush, in_valid;
    logic [AW-1:0]     in_rs1, in_rs2, in_rd, lw_waddr;
    logic              in_rs1_en, in_rs2_en, in_rd_we, in_long, lw_valid;
    logic [XLEN-1:0]   rf_rdata1, rf_rdata2, src1, src2;
    logic [NBYP*BW-1:0] byp_bus;
    logic              stallreq, issue;
    logic [31:0]       sb_busy;
    logic [1:0]        long_cnt;
    logic [15:0]       stall_cnt;

    typedef struct {
        int          id;
        logic [63:0] val;
    } exp_t;
    exp_t exp_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    id_fwd_hazard dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush), .in_valid(in_valid),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_long(in_long),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .byp_bus(byp_bus),
        .lw_valid(lw_valid), .lw_waddr(lw_waddr),
        .src1(src1), .src2(src2), .stallreq(stallreq), .issue(issue),
        .sb_busy(sb_busy), .long_cnt(long_cnt), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        stall_in = 0; flush = 0; in_valid = 0;
        in_rs1 = 0; in_rs2 = 0; in_rs1_en = 0; in_rs2_en = 0;
        in_rd = 0; in_rd_we = 0; in_long = 0;
        rf_rdata1 = 32'h1111_1111; rf_rdata2 = 32'h2222_2222;
        byp_bus = '0; lw_valid = 0; lw_waddr = 0;
    endtask

    task automatic byp(input int i, input logic we, input logic rdy,
                       input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        byp_bus[i*BW +: BW] = {we, rdy, a, d};
    endtask

    task automatic expect_v(input int id, input logic [63:0] v);
        exp_t e;
        e.id = id; e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string step);
        exp_t        e;
        logic [63:0] obs;
        string       nm;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.id)
                S_SRC1:  begin obs = 64'(src1);      nm = "src1";      end
                S_SRC2:  begin obs = 64'(src2);      nm = "src2";      end
                S_STALL: begin obs = 64'(stallreq);  nm = "stallreq";  end
                S_ISSUE: begin obs = 64'(issue);     nm = "issue";     end
                S_BUSY:  begin obs = 64'(sb_busy);   nm = "sb_busy";   end
                S_LCNT:  begin obs = 64'(long_cnt);  nm = "long_cnt";  end
                default: begin obs = 64'(stall_cnt); nm = "stall_cnt"; end
            endcase
            n_assert++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s.%s observed=%0h expected=%0h", step, nm, obs, e.val);
            end
        end
    endtask

    initial begin
        rst = 1; idle();
        expect_v(S_BUSY, 0); expect_v(S_LCNT, 0); expect_v(S_SCNT, 0);
        chk("reset");
        @(negedge clk); rst = 0;

        // youngest of two ready matches wins; rs2 without match takes regfile
        @(negedge clk); idle();
        in_valid = 1; in_rs1 = 5; in_rs1_en = 1; in_rs2 = 3; in_rs2_en = 1;
        byp(1, 1, 1, 5, 32'hAAAA_0001); byp(3, 1, 1, 5, 32'h0000_BBBB);
        expect_v(S_SRC1, 32'hAAAA_0001); expect_v(S_SRC2, 32'h2222_2222);
        expect_v(S_STALL, 0); expect_v(S_ISSUE, 1);
        chk("prio");

        // youngest match not ready stalls even though an older one is ready
        @(negedge clk); idle();
        in_valid = 1; in_rs2 = 7; in_rs2_en = 1;
        byp(0, 1, 0, 7, 32'hDEAD_0000); byp(2, 1, 1, 7, 32'h5555_5555);
        expect_v(S_STALL, 1); expect_v(S_ISSUE, 0); expect_v(S_SRC1, 0);
        chk("raw_stall");

        @(negedge clk); idle();
        in_valid = 1; in_rs2 = 7; in_rs2_en = 1;
        byp(0, 1, 1, 7, 32'h0000_1234); byp(2, 1, 1, 7, 32'h5555_5555);
        expect_v(S_SRC2, 32'h1234); expect_v(S_ISSUE, 1); expect_v(S_STALL, 0);
        expect_v(S_SCNT, 1);
        chk("raw_release");

        // x0 and disabled sources ignore non-ready bypass entries
        @(negedge clk); idle();
        in_valid = 1; in_rs1 = 0; in_rs1_en = 1; in_rs2 = 7; in_rs2_en = 0;
        byp(0, 1, 0, 0, 32'hDEAD_BEEF); byp(1, 1, 0, 7, 32'hBEEF_0000);
        expect_v(S_SRC1, 0); expect_v(S_SRC2, 32'h2222_2222);
        expect_v(S_STALL, 0); expect_v(S_ISSUE, 1);
        chk("x0_en");

        @(negedge clk); idle();
        in_valid = 1; in_long = 1; in_rd = 9; in_rd_we = 1;
        expect_v(S_ISSUE, 1); expect_v(S_STALL, 0);
        chk("long9");

        @(negedge clk); idle();
        in_valid = 1; in_rs1 = 9; in_rs1_en = 1;
        expect_v(S_BUSY, 32'h200); expect_v(S_LCNT, 1);
        expect_v(S_STALL, 1); expect_v(S_ISSUE, 0);
        chk("sb_stall");

        @(negedge clk); idle();
        in_valid = 1; in_rs1 = 9; in_rs1_en = 1; lw_valid = 1; lw_waddr = 9;
        expect_v(S_STALL, 0); expect_v(S_ISSUE, 1); expect_v(S_SCNT, 2);
        chk("sb_bypass_clr");

        @(negedge clk); idle();
        expect_v(S_BUSY, 0); expect_v(S_LCNT, 0);
        chk("sb_cleared");

        @(negedge clk); idle();
        in_valid = 1; in_long = 1; in_rd = 10; in_rd_we = 1;
        expect_v(S_ISSUE, 1);
        chk("long10");

        @(negedge clk); idle();
        in_valid = 1; in_long = 1; in_rd = 11; in_rd_we = 1;
        expect_v(S_ISSUE, 1); expect_v(S_LCNT, 1);
        chk("long11");

        @(negedge clk); idle();
        in_valid = 1; in_long = 1; in_rd = 12; in_rd_we = 1;
        expect_v(S_STALL, 1); expect_v(S_ISSUE, 0); expect_v(S_LCNT, 2);
        chk("cap_stall");

        @(negedge clk); idle();
        in_valid = 1; in_long = 1; in_rd = 12; in_rd_we = 1; lw_valid = 1; lw_waddr = 10;
        expect_v(S_STALL, 0); expect_v(S_ISSUE, 1);
        chk("cap_release");

        @(negedge clk); idle();
        expect_v(S_LCNT, 2); expect_v(S_BUSY, 32'h1800); expect_v(S_SCNT, 3);
        chk("cap_after");

        @(negedge clk); idle();
        in_valid = 1; in_rd = 11; in_rd_we = 1;
        expect_v(S_STALL, 1); expect_v(S_ISSUE, 0);
        chk("waw");

        // completion and new long op to the same register: set wins
        @(negedge clk); idle();
        in_valid = 1; in_long = 1; in_rd = 11; in_rd_we = 1; lw_valid = 1; lw_waddr = 11;
        expect_v(S_STALL, 0); expect_v(S_ISSUE, 1);
        chk("set_wins");

        @(negedge clk); idle();
        expect_v(S_BUSY, 32'h1800); expect_v(S_LCNT, 2); expect_v(S_SCNT, 4);
        chk("set_wins_after");

        @(negedge clk); idle();
        in_valid = 1; in_rd = 14; in_rd_we = 1; stall_in = 1;
        expect_v(S_STALL, 0); expect_v(S_ISSUE, 0);
        chk("stall_in");

        @(negedge clk); idle();
        in_valid = 1; in_long = 1; in_rd = 13; in_rd_we = 1; flush = 1;
        lw_valid = 1; lw_waddr = 12;
        expect_v(S_STALL, 0); expect_v(S_ISSUE, 0);
        chk("flush");

        @(negedge clk); idle();
        expect_v(S_BUSY, 32'h0800); expect_v(S_LCNT, 1);
        chk("flush_after");

        @(negedge clk); rst = 1;
        #1; rst = 0;
        expect_v(S_BUSY, 0); expect_v(S_LCNT, 0); expect_v(S_SCNT, 0);
        chk("reset2");

        @(negedge clk); idle();
        in_valid = 1; in_long = 1; in_rd = 9; in_rd_we = 1;
        expect_v(S_ISSUE, 1);
        chk("long9b");

        @(negedge clk); idle();
        in_valid = 1; in_rs1 = 9; in_rs1_en = 1;
        expect_v(S_STALL, 1); expect_v(S_BUSY, 32'h200); expect_v(S_SCNT, 0);
        chk("hold_start");
        repeat (5) @(posedge clk);
        @(negedge clk);
        expect_v(S_SCNT, 5); expect_v(S_STALL, 1);
        chk("hold5");

        rst = 1;
        expect_v(S_BUSY, 0); expect_v(S_LCNT, 0); expect_v(S_SCNT, 0);
        chk("async_rst");
        @(negedge clk); rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
